ysyx_22050854_regfile_mp: RTL and testbench

Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard. It replaces the single-write, two-read register file in the CPU datapath and is the architectural register store for the decode/issue stage of the pipelined core. The write-back stage writes it, and decode reads it. Issue marks destination registers pending so that decode can stall on RAW hazards without a separate hazard unit.

---
 rtl/ysyx_22050854_rf_pkg.sv | 14 +
 rtl/ysyx_22050854_rf_scoreboard.sv | 56 +++++
 rtl/ysyx_22050854_regfile_mp.sv | 86 ++++++++
 tb/tb_ysyx_22050854_regfile_mp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050854_rf_pkg.sv
// Shared constants and types for the multi-port register file.
// Imported by the scoreboard and the top-level register file.
package ysyx_22050854_rf_pkg;

  localparam int RF_XLEN = 64;
  localparam int RF_NREG = 32;

  typedef logic [RF_XLEN-1:0] xreg_t;

  function automatic int rf_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_22050854_rf_scoreboard.sv
// Per-register busy flags for RAW stall detection.
// Priority: flush, then issue-set, then write-clear.
module ysyx_22050854_rf_scoreboard
  import ysyx_22050854_rf_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int AW   = rf_aw(NREG),
  parameter int NWR  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  output logic [NREG-1:0]   busy_vec,
  output logic [NREG-1:0]   wr_hit
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NWR; w++)
      if (wr_en[w])
        wr_hit[wr_addr[w*AW +: AW]] = 1'b1;
    wr_hit[0] = 1'b0;
  end

  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (iss_valid && iss_addr == AW'(r))
          busy_nxt[r] = 1'b1;
        else if (wr_hit[r])
          busy_nxt[r] = 1'b0;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign busy_vec = busy;

endmodule

// File: rtl/ysyx_22050854_regfile_mp.sv
// Multi-port integer register file with write bypass and busy scoreboard.
// Higher-index write ports win collisions; x0 is hardwired to zero.
module ysyx_22050854_regfile_mp
  import ysyx_22050854_rf_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREG   = RF_NREG,
  parameter int AW     = rf_aw(NREG),
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] mem [NREG];
  logic [NWR-1:0][NREG-1:0] wdec;
  logic [NREG-1:0] wr_hit;

  ysyx_22050854_rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .NWR  (NWR)
  ) u_sb (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .busy_vec  (busy_vec),
    .wr_hit    (wr_hit)
  );

  for (genvar w = 0; w < NWR; w++) begin : g_wr
    assign wdec[w] = wr_en[w]
      ? (NREG'(1) << wr_addr[w*AW +: AW])
      : '0;
  end

  // Ascending port order: the last matching port overrides.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++)
        mem[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++)
        for (int w = 0; w < NWR; w++)
          if (wdec[w][r])
            mem[r] <= wr_data[w*XLEN +: XLEN];
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] val;
    assign ra = rd_addr[p*AW +: AW];
    always_comb begin
      val = mem[ra];
      if (BYPASS != 0 && reset_n && ra != '0)
        for (int w = 0; w < NWR; w++)
          if (wdec[w][ra])
            val = wr_data[w*XLEN +: XLEN];
    end
    assign rd_data[p*XLEN +: XLEN] = val;
    assign rd_busy[p] = busy_vec[ra]
      & ~((BYPASS != 0) & wr_hit[ra]);
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_ysyx_22050854_regfile_mp.sv
// Directed bench for the multi-port register file.
// Drives a BYPASS=1 and a BYPASS=0 instance with shared stimulus.
module tb_ysyx_22050854_regfile_mp;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic                clock;
  logic                reset_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                flush;
  logic [AW-1:0]       dbg_addr;

  logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]      rd_busy_b, rd_busy_n;
  logic [XLEN-1:0]     dbg_data_b, dbg_data_n;
  logic [31:0]         busy_vec_b, busy_vec_n;

  int checks = 0;
  int errors = 0;

  ysyx_22050854_regfile_mp #(.BYPASS(1)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data_b),
    .rd_busy   (rd_busy_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data_b),
    .busy_vec  (busy_vec_b)
  );

  ysyx_22050854_regfile_mp #(.BYPASS(0)) dut_nb (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data_n),
    .rd_busy   (rd_busy_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .flush     (flush),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data_n),
    .busy_vec  (busy_vec_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic set_wr(input int p, input logic en,
                        input logic [AW-1:0] a,
                        input logic [XLEN-1:0] d);
    wr_en[p] = en;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic idle;
    wr_en = '0;
    iss_valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    rd_addr = '0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    iss_valid = 1'b0;
    iss_addr = '0;
    flush = 1'b0;
    dbg_addr = '0;

    // Writes and issues during reset must be lost
    set_wr(0, 1'b1, 5'd0, 64'hDEAD);
    set_wr(1, 1'b1, 5'd6, 64'h55);
    iss_valid = 1'b1;
    iss_addr = 5'd0;
    set_rd(0, 5'd0);
    set_rd(1, 5'd6);
    dbg_addr = 5'd6;
    step;
    step;
    #1;
    chk("rst_busy_vec", 64'(busy_vec_b), 64'h0);
    chk("rst_dbg", dbg_data_b, 64'h0);
    chk("rst_rd0", rd_data_b[63:0], 64'h0);
    chk("rst_rd1_bypass", rd_data_b[127:64], 64'h0);
    chk("rst_rd_busy", 64'(rd_busy_b), 64'h0);

    // x0: write and issue after reset release
    reset_n = 1'b1;
    set_wr(1, 1'b0, 5'd0, 64'h0);
    dbg_addr = 5'd0;
    #1;
    chk("x0_bypass", rd_data_b[63:0], 64'h0);
    step;
    idle;
    #1;
    chk("x0_busy_vec", 64'(busy_vec_b), 64'h0);
    chk("x0_dbg", dbg_data_b, 64'h0);
    chk("x0_rd0", rd_data_b[63:0], 64'h0);

    // Write collision on register 5
    set_wr(0, 1'b1, 5'd5, 64'h11);
    set_wr(1, 1'b1, 5'd5, 64'h22);
    set_rd(0, 5'd5);
    #1;
    chk("coll_bypass", rd_data_b[63:0], 64'h22);
    step;
    idle;
    dbg_addr = 5'd5;
    #1;
    chk("coll_rd_b", rd_data_b[63:0], 64'h22);
    chk("coll_rd_n", rd_data_n[63:0], 64'h22);
    chk("coll_dbg", dbg_data_b, 64'h22);

    // Bypass vs no bypass on register 7
    set_wr(0, 1'b1, 5'd7, 64'h1);
    step;
    set_wr(0, 1'b1, 5'd7, 64'h1234);
    set_rd(0, 5'd7);
    #1;
    chk("byp_same_b", rd_data_b[63:0], 64'h1234);
    chk("byp_same_n", rd_data_n[63:0], 64'h1);
    step;
    idle;
    #1;
    chk("byp_next_n", rd_data_n[63:0], 64'h1234);

    // Scoreboard life-cycle on register 3
    iss_valid = 1'b1;
    iss_addr = 5'd3;
    set_rd(1, 5'd3);
    step;
    idle;
    #1;
    chk("sb_busy_c1", 64'(busy_vec_b), 64'h8);
    step;
    #1;
    chk("sb_busy_c2", 64'(busy_vec_b), 64'h8);
    chk("sb_rdbusy_b", 64'(rd_busy_b[1]), 64'h1);
    chk("sb_rdbusy_n", 64'(rd_busy_n[1]), 64'h1);
    set_wr(0, 1'b1, 5'd3, 64'hAB);
    #1;
    chk("sb_wr_rdbusy_b", 64'(rd_busy_b[1]), 64'h0);
    chk("sb_wr_rdbusy_n", 64'(rd_busy_n[1]), 64'h1);
    chk("sb_wr_rd1_b", rd_data_b[127:64], 64'hAB);
    step;
    idle;
    #1;
    chk("sb_clear", 64'(busy_vec_b), 64'h0);

    // Issue and write to register 9 in the same cycle
    iss_valid = 1'b1;
    iss_addr = 5'd9;
    set_wr(1, 1'b1, 5'd9, 64'h99);
    step;
    idle;
    dbg_addr = 5'd9;
    #1;
    chk("race_iss_wr", 64'(busy_vec_b), 64'h200);
    chk("race_iss_wr_dbg", dbg_data_b, 64'h99);

    // Flush with issue to register 4
    flush = 1'b1;
    iss_valid = 1'b1;
    iss_addr = 5'd4;
    step;
    idle;
    #1;
    chk("flush_b", 64'(busy_vec_b), 64'h0);
    chk("flush_n", 64'(busy_vec_n), 64'h0);

    // Asynchronous reset in mid-cycle
    iss_valid = 1'b1;
    iss_addr = 5'd12;
    step;
    idle;
    dbg_addr = 5'd5;
    set_rd(0, 5'd5);
    #1;
    chk("pre_rst_busy", 64'(busy_vec_b), 64'h1000);
    chk("pre_rst_dbg", dbg_data_b, 64'h22);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_dbg", dbg_data_b, 64'h0);
    chk("arst_busy", 64'(busy_vec_b), 64'h0);
    chk("arst_rd0", rd_data_b[63:0], 64'h0);
    #1;
    reset_n = 1'b1;

    // Normal writes resume after reset
    step;
    set_wr(0, 1'b1, 5'd5, 64'h77);
    step;
    idle;
    #1;
    chk("post_rst_wr", rd_data_n[63:0], 64'h77);
    chk("post_rst_busy", 64'(busy_vec_b), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
